// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the instruction cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package icache_pkg;

    localparam int OFFSET_W = 5;
    localparam int INDEX_W  = 4;
    localparam int TAG_W    = 23;
    localparam int LINE_W   = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } icache_state_t;

    // Line index: the bits just above the byte offset.
    function automatic logic [INDEX_W-1:0] get_index(input logic [31:0] addr);
        return addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    endfunction

    // Tag: everything above the index.
    function automatic logic [TAG_W-1:0] get_tag(input logic [31:0] addr);
        return addr[31:OFFSET_W+INDEX_W];
    endfunction

    // 32-bit word within the line; the two byte bits are ignored.
    function automatic logic [2:0] get_word(input logic [31:0] addr);
        return addr[4:2];
    endfunction

endpackage

// File: rtl/icache_sram.sv
// Tag/data storage with a separately reset valid vector.
// Latency: read is combinational, write lands at the next rising edge.
// Backpressure: none; clear-all takes priority over the valid set of a write.
module icache_sram
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_vld,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_line,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [LINE_W-1:0]  wr_line,
    input  logic               clr_all
);

    logic [TAG_W-1:0]  tag_mem  [NUM_LINES];
    logic [LINE_W-1:0] data_mem [NUM_LINES];
    logic [NUM_LINES-1:0] valid;

    // Tag and data arrays carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_line;
        end
    end

    // Valid bits: clear-all wins so an invalidate racing a fill leaves the new line invalid.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid <= '0;
        end else if (clr_all) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    assign rd_vld  = valid[rd_idx];
    assign rd_tag  = tag_mem[rd_idx];
    assign rd_line = data_mem[rd_idx];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped read-only I-cache: same-cycle hit, blocking single-line refill on miss.
// Latency: hit 0 cycles; miss costs L+2 stall cycles for a memory ack L cycles after detect.
// Backpressure: cpu_stall_o holds fetch from the miss-detect cycle through FILL.
module icache_controller
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic              inv_i,
    output logic [31:0]       cpu_instr_o,
    output logic              cpu_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    icache_state_t state, state_nxt;

    logic [TAG_W-1:0]   lat_tag;
    logic [INDEX_W-1:0] lat_idx;
    logic [LINE_W-1:0]  line_buf;
    logic               inv_sticky;

    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [2:0]         req_word;
    logic               rd_vld;
    logic [TAG_W-1:0]   rd_tag;
    logic [LINE_W-1:0]  rd_line;
    logic               hit;
    logic               wr_en;
    logic               clr_all;
    logic               unused_addr_bits;

    assign req_idx  = get_index(cpu_addr_i);
    assign req_tag  = get_tag(cpu_addr_i);
    assign req_word = get_word(cpu_addr_i);
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign hit = cpu_req_i && (state == IDLE) && rd_vld && (rd_tag == req_tag);

    // Invalidates seen mid-refill are applied when FILL hands back to IDLE.
    assign wr_en   = (state == FILL);
    assign clr_all = ((state == IDLE) && inv_i) ||
                     ((state == FILL) && (inv_sticky || inv_i));

    icache_sram #(
        .NUM_LINES (NUM_LINES)
    ) u_sram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .rd_idx  (req_idx),
        .rd_vld  (rd_vld),
        .rd_tag  (rd_tag),
        .rd_line (rd_line),
        .wr_en   (wr_en),
        .wr_idx  (lat_idx),
        .wr_tag  (lat_tag),
        .wr_line (line_buf),
        .clr_all (clr_all)
    );

    // State register plus latched miss address and sticky invalidate.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            lat_tag    <= '0;
            lat_idx    <= '0;
            inv_sticky <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && cpu_req_i && !hit) begin
                lat_tag <= req_tag;
                lat_idx <= req_idx;
            end
            if (state == FILL) begin
                inv_sticky <= 1'b0;
            end else if ((state == REQ) && inv_i) begin
                inv_sticky <= 1'b1;
            end
        end
    end

    // Refill line is captured on the ack and written to the arrays in FILL.
    always_ff @(posedge clk_i) begin
        if ((state == REQ) && mem_ack_i) begin
            line_buf <= mem_data_i;
        end
    end

    // Next state and fetch/memory outputs; memory outputs depend on state only
    // so an asynchronous reset drops the request immediately.
    always_comb begin
        state_nxt    = state;
        cpu_instr_o  = '0;
        cpu_stall_o  = 1'b0;
        mem_enable_o = 1'b0;
        mem_addr_o   = '0;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    cpu_instr_o = rd_line[32*req_word +: 32];
                end else if (cpu_req_i) begin
                    cpu_stall_o = 1'b1;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {lat_tag, lat_idx, {OFFSET_W{1'b0}}};
                if (mem_ack_i) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                cpu_stall_o = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
